// File: rtl/uart_wb_regs.sv
// 16550-style UART register file behind an 8-bit Wishbone responder.
// Optional scratch register at address 7 enabled by UART_WB_REGS_SCRATCH_EN.
module uart_wb_regs #(
  parameter logic [15:0] DL_RESET = 16'h0000
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic [2:0]  i_wb_adr,
  input  logic [7:0]  i_wb_dat,
  input  logic        i_wb_we,
  input  logic        i_wb_stb,
  input  logic        i_wb_cyc,
  input  logic        i_wb_sel,
  output logic [7:0]  o_wb_dat,
  output logic        o_wb_ack,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic [15:0] o_divisor,
  output logic [7:0]  o_line_ctrl,
  output logic        o_interrupt
);

  localparam logic [2:0] A_RB_TR = 3'd0;
  localparam logic [2:0] A_IE    = 3'd1;
  localparam logic [2:0] A_II_FC = 3'd2;
  localparam logic [2:0] A_LC    = 3'd3;
  localparam logic [2:0] A_LS    = 3'd5;
  localparam logic [2:0] A_SCR   = 3'd7;

  typedef enum logic {S_IDLE = 1'b0, S_ACK = 1'b1} state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_accept;

  logic [7:0]  r_rdata;
  logic [7:0]  r_lc;
  logic [15:0] r_dl;
  logic [3:0]  r_ie;
  logic [1:0]  r_fc;
  logic [7:0]  r_rb;
  logic        r_dr;
  logic        r_oe;
  logic [7:0]  r_thr;
  logic        r_tx_valid;

  logic        w_dlab;
  logic        w_wr;
  logic        w_rd;
  logic        w_tr_wr;
  logic        w_dl1_wr;
  logic        w_dl2_wr;
  logic        w_ie_wr;
  logic        w_fc_wr;
  logic        w_lc_wr;
  logic        w_rb_rd;
  logic        w_ls_rd;
  logic        w_thr_load;
  logic        w_thre;
  logic [7:0]  w_ls;
  logic [3:0]  w_ii_hi;
  logic [3:0]  w_ii_lo;
  logic [7:0]  w_ii;
  logic [7:0]  w_scr;
  logic [7:0]  w_rdata;
  logic        w_unused;

  // Bus FSM: state register
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Bus FSM: next state
  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE:  w_next = (i_wb_cyc && i_wb_stb) ? S_ACK : S_IDLE;
      S_ACK:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Bus FSM: outputs
  always_comb begin
    o_wb_ack = 1'b0;
    w_accept = 1'b0;
    case (r_state)
      S_IDLE:  w_accept = i_wb_cyc && i_wb_stb;
      S_ACK:   o_wb_ack = 1'b1;
      default: ;
    endcase
  end

  assign w_unused = i_wb_sel;

  assign w_dlab     = r_lc[7];
  assign w_wr       = w_accept && i_wb_we;
  assign w_rd       = w_accept && !i_wb_we;
  assign w_tr_wr    = w_wr && (i_wb_adr == A_RB_TR) && !w_dlab;
  assign w_dl1_wr   = w_wr && (i_wb_adr == A_RB_TR) && w_dlab;
  assign w_dl2_wr   = w_wr && (i_wb_adr == A_IE) && w_dlab;
  assign w_ie_wr    = w_wr && (i_wb_adr == A_IE) && !w_dlab;
  assign w_fc_wr    = w_wr && (i_wb_adr == A_II_FC);
  assign w_lc_wr    = w_wr && (i_wb_adr == A_LC);
  assign w_rb_rd    = w_rd && (i_wb_adr == A_RB_TR) && !w_dlab;
  assign w_ls_rd    = w_rd && (i_wb_adr == A_LS);
  // A full THR still takes the new byte when the serializer drains it this cycle
  assign w_thr_load = w_tr_wr && (!r_tx_valid || i_tx_ready);

  assign w_thre = !r_tx_valid;
  assign w_ls   = {1'b0, w_thre, w_thre, 3'b000, r_oe, r_dr};

  always_comb begin
    if (r_ie[2] && r_oe)        w_ii_lo = 4'h6;
    else if (r_ie[0] && r_dr)   w_ii_lo = 4'h4;
    else if (r_ie[1] && w_thre) w_ii_lo = 4'h2;
    else                        w_ii_lo = 4'h1;
  end
  assign w_ii_hi = (r_fc != 2'b00) ? {r_fc, 2'b00} : 4'hC;
  assign w_ii    = {w_ii_hi, w_ii_lo};

  always_comb begin
    w_rdata = 8'h00;
    case (i_wb_adr)
      A_RB_TR: w_rdata = w_dlab ? r_dl[7:0]  : r_rb;
      A_IE:    w_rdata = w_dlab ? r_dl[15:8] : {4'h0, r_ie};
      A_II_FC: w_rdata = w_ii;
      A_LC:    w_rdata = r_lc;
      A_LS:    w_rdata = w_ls;
      A_SCR:   w_rdata = w_scr;
      default: w_rdata = 8'h00;
    endcase
  end

  // Read data is only non-zero during the ack cycle
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) r_rdata <= 8'h00;
    else         r_rdata <= w_rd ? w_rdata : 8'h00;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_lc <= 8'h03;
      r_dl <= DL_RESET;
      r_ie <= 4'h0;
      r_fc <= 2'b11;
    end else begin
      if (w_lc_wr)  r_lc       <= i_wb_dat;
      if (w_dl1_wr) r_dl[7:0]  <= i_wb_dat;
      if (w_dl2_wr) r_dl[15:8] <= i_wb_dat;
      if (w_ie_wr)  r_ie       <= i_wb_dat[3:0];
      if (w_fc_wr)  r_fc       <= i_wb_dat[7:6];
    end
  end

  // Incoming byte beats both an RB read and an RX clear in the same cycle
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_rb <= 8'h00;
      r_dr <= 1'b0;
    end else if (i_rx_valid) begin
      r_rb <= i_rx_data;
      r_dr <= 1'b1;
    end else if (w_fc_wr && i_wb_dat[1]) begin
      r_rb <= 8'h00;
      r_dr <= 1'b0;
    end else if (w_rb_rd) begin
      r_dr <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)                  r_oe <= 1'b0;
    else if (i_rx_valid && r_dr)  r_oe <= 1'b1;
    else if (w_ls_rd)             r_oe <= 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_thr      <= 8'h00;
      r_tx_valid <= 1'b0;
    end else if (w_fc_wr && i_wb_dat[2]) begin
      r_thr      <= 8'h00;
      r_tx_valid <= 1'b0;
    end else if (w_thr_load) begin
      r_thr      <= i_wb_dat;
      r_tx_valid <= 1'b1;
    end else if (r_tx_valid && i_tx_ready) begin
      r_tx_valid <= 1'b0;
    end
  end

`ifdef UART_WB_REGS_SCRATCH_EN
  logic [7:0] r_scr;
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)                             r_scr <= 8'h00;
    else if (w_wr && (i_wb_adr == A_SCR))    r_scr <= i_wb_dat;
  end
  assign w_scr = r_scr;
`else
  assign w_scr = 8'h00;
`endif

  assign o_wb_dat    = r_rdata;
  assign o_tx_data   = r_thr;
  assign o_tx_valid  = r_tx_valid;
  assign o_divisor   = r_dl;
  assign o_line_ctrl = r_lc;
  assign o_interrupt = (r_ie[0] && r_dr) || (r_ie[1] && w_thre) || (r_ie[2] && r_oe);

endmodule

// File: tb/tb_uart_wb_regs.sv
// Bench for uart_wb_regs: directed register scenarios plus randomized traffic
// compared every cycle against a transaction-level model of the register file.
module tb_uart_wb_regs;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [2:0]  adr = 3'd0;
  logic [7:0]  dat = 8'h00;
  logic        we = 1'b0, stb = 1'b0, cyc = 1'b0, sel = 1'b1;
  logic        txr = 1'b0, rxv = 1'b0;
  logic [7:0]  rxd = 8'h00;
  logic [7:0]  d_rdat, d_txd;
  logic        d_ack, d_txv, d_irq;
  logic [15:0] d_div;
  logic [7:0]  d_lc;

  int n_chk = 0, n_pass = 0;
  bit chk_en = 1'b0;

  uart_wb_regs #(.DL_RESET(16'h0000)) dut (
    .i_clk(clk), .i_rstn(rstn),
    .i_wb_adr(adr), .i_wb_dat(dat), .i_wb_we(we), .i_wb_stb(stb), .i_wb_cyc(cyc), .i_wb_sel(sel),
    .o_wb_dat(d_rdat), .o_wb_ack(d_ack),
    .o_tx_data(d_txd), .o_tx_valid(d_txv), .i_tx_ready(txr),
    .i_rx_data(rxd), .i_rx_valid(rxv),
    .o_divisor(d_div), .o_line_ctrl(d_lc), .o_interrupt(d_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        busy;
    logic [7:0]  rdata;
    logic [7:0]  lc;
    logic [15:0] dl;
    logic [3:0]  ie;
    logic [1:0]  fc;
    logic [7:0]  rb;
    logic        dr, oe;
    logic [7:0]  thr;
    logic        tv;
    logic [7:0]  scr;
  } ms_t;

  ms_t m;

  function automatic ms_t m_reset();
    ms_t s;
    s = '0;
    s.lc = 8'h03;
    s.fc = 2'b11;
    return s;
  endfunction

  function automatic logic [7:0] m_ls(ms_t s);
    return (s.tv ? 8'h00 : 8'h60) | (s.oe ? 8'h02 : 8'h00) | (s.dr ? 8'h01 : 8'h00);
  endfunction

  function automatic logic [7:0] m_read(ms_t s, logic [2:0] a);
    int lo, hi;
    case (a)
      3'd0: return s.lc[7] ? s.dl[7:0] : s.rb;
      3'd1: return s.lc[7] ? s.dl[15:8] : {4'h0, s.ie};
      3'd2: begin
        if (s.ie[2] && s.oe)      lo = 6;
        else if (s.ie[0] && s.dr) lo = 4;
        else if (s.ie[1] && !s.tv) lo = 2;
        else                      lo = 1;
        hi = (s.fc == 2'b00) ? 12 : s.fc * 4;
        return 8'(hi * 16 + lo);
      end
      3'd3: return s.lc;
      3'd5: return m_ls(s);
`ifdef UART_WB_REGS_SCRATCH_EN
      3'd7: return s.scr;
`endif
      default: return 8'h00;
    endcase
  endfunction

  function automatic ms_t m_next(ms_t s);
    ms_t n;
    bit take;
    n = s;
    take = !s.busy && cyc && stb;
    n.busy  = take;
    n.rdata = (take && !we) ? m_read(s, adr) : 8'h00;
    if (s.tv && txr) n.tv = 1'b0;
    if (take && !we) begin
      if (adr == 3'd0 && !s.lc[7]) n.dr = 1'b0;
      if (adr == 3'd5)             n.oe = 1'b0;
    end
    if (take && we) begin
      case (adr)
        3'd0: if (s.lc[7]) n.dl[7:0] = dat;
              else if (!s.tv || txr) begin n.thr = dat; n.tv = 1'b1; end
        3'd1: if (s.lc[7]) n.dl[15:8] = dat; else n.ie = dat[3:0];
        3'd2: begin
          n.fc = dat[7:6];
          if (dat[1]) begin n.rb = 8'h00; n.dr = 1'b0; end
          if (dat[2]) begin n.thr = 8'h00; n.tv = 1'b0; end
        end
        3'd3: n.lc = dat;
        3'd7: n.scr = dat;
        default: ;
      endcase
    end
    if (rxv) begin
      n.rb = rxd;
      n.dr = 1'b1;
      if (s.dr) n.oe = 1'b1;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) m <= m_reset();
    else       m <= m_next(m);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ack",       {15'h0, d_ack}, {15'h0, m.busy});
      chk("data_in",   {8'h0, d_rdat}, {8'h0, m.rdata});
      chk("tx_valid",  {15'h0, d_txv}, {15'h0, m.tv});
      chk("tx_data",   {8'h0, d_txd},  {8'h0, m.thr});
      chk("divisor",   d_div,          m.dl);
      chk("line_ctrl", {8'h0, d_lc},   {8'h0, m.lc});
      chk("interrupt", {15'h0, d_irq},
          {15'h0, (m.ie[0] & m.dr) | (m.ie[1] & ~m.tv) | (m.ie[2] & m.oe)});
    end
  end

  // ---------------- bus tasks (called at posedge+1) ----------------
  task automatic wb_xfer(input logic w, input logic [2:0] a, input logic [7:0] d, output logic [7:0] rd);
    int n;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!d_ack && n < 8);
    chk("ack_latency", 16'(n), 16'd1);
    rd = d_rdat;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wb_wr(input logic [2:0] a, input logic [7:0] d);
    logic [7:0] unused_rd;
    wb_xfer(1'b1, a, d, unused_rd);
  endtask

  task automatic wb_rd_chk(input string nm, input logic [2:0] a, input logic [7:0] exp);
    logic [7:0] rd;
    wb_xfer(1'b0, a, 8'h00, rd);
    chk(nm, {8'h0, rd}, {8'h0, exp});
  endtask

  task automatic rx_pulse(input logic [7:0] d);
    rxv = 1'b1; rxd = d;
    @(posedge clk); #1;
    rxv = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack",       {15'h0, d_ack}, 16'h0);
    chk("rst_data_in",   {8'h0, d_rdat}, 16'h0);
    chk("rst_line_ctrl", {8'h0, d_lc},   16'h0003);
    chk("rst_divisor",   d_div,          16'h0000);
    chk("rst_tx_valid",  {15'h0, d_txv}, 16'h0);
    chk("rst_tx_data",   {8'h0, d_txd},  16'h0);
    chk("rst_interrupt", {15'h0, d_irq}, 16'h0);
    rstn = 1'b1;
    chk_en = 1'b1;
    @(posedge clk); #1;

    // divisor programming through DLAB
    wb_wr(3'd3, 8'h83);
    wb_wr(3'd1, 8'h00);
    wb_wr(3'd0, 8'h82);
    wb_wr(3'd3, 8'h03);
    chk("dl_divisor", d_div, 16'h0082);
    chk("dl_line_ctrl", {8'h0, d_lc}, 16'h0003);

    // receive path with DR interrupt
    wb_wr(3'd1, 8'h01);
    rx_pulse(8'h5A);
    chk("rx_irq_set", {15'h0, d_irq}, 16'h1);
    wb_rd_chk("rx_ls_61", 3'd5, 8'h61);
    wb_rd_chk("rx_ii_c4", 3'd2, 8'hC4);
    wb_rd_chk("rx_rb_5a", 3'd0, 8'h5A);
    chk("rx_irq_clr", {15'h0, d_irq}, 16'h0);
    wb_rd_chk("rx_ls_60", 3'd5, 8'h60);

    // overrun
    rx_pulse(8'h11);
    rx_pulse(8'h22);
    wb_rd_chk("oe_ls_63", 3'd5, 8'h63);
    wb_rd_chk("oe_rb_22", 3'd0, 8'h22);
    wb_rd_chk("oe_ls_60", 3'd5, 8'h60);

    // transmit holding register, second write dropped
    txr = 1'b0;
    wb_wr(3'd0, 8'hA5);
    wb_wr(3'd0, 8'h3C);
    chk("tx_data_a5", {8'h0, d_txd}, 16'h00A5);
    chk("tx_valid_1", {15'h0, d_txv}, 16'h1);
    wb_rd_chk("tx_ls_00", 3'd5, 8'h00);
    txr = 1'b1;
    @(posedge clk); #1;
    txr = 1'b0;
    chk("tx_valid_0", {15'h0, d_txv}, 16'h0);
    wb_rd_chk("tx_ls_60", 3'd5, 8'h60);

    // scratch register
`ifdef UART_WB_REGS_SCRATCH_EN
    wb_wr(3'd7, 8'h9C);
    wb_rd_chk("scratch", 3'd7, 8'h9C);
`else
    wb_wr(3'd7, 8'h9C);
    wb_rd_chk("scratch", 3'd7, 8'h00);
`endif

    // reset during the ack cycle of an IE write
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 3'd1; dat = 8'h07;
    @(posedge clk); #1;
    chk("abort_ack_hi", {15'h0, d_ack}, 16'h1);
    rstn = 1'b0;
    #1;
    chk("abort_ack_lo", {15'h0, d_ack}, 16'h0);
    chk("abort_data_in", {8'h0, d_rdat}, 16'h0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    wb_rd_chk("abort_ie_00", 3'd1, 8'h00);
    wb_rd_chk("abort_lc_03", 3'd3, 8'h03);

    // II upper nibble follows FC[7:6] unless zero
    wb_wr(3'd2, 8'h40);
    wb_rd_chk("ii_fc40", 3'd2, 8'h41);
    wb_wr(3'd2, 8'h00);
    wb_rd_chk("ii_fc00", 3'd2, 8'hC1);

    // randomized traffic, checked by the per-cycle compare against the model
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      if (stb && d_ack) begin
        if ($urandom_range(0, 4) != 0) begin stb = 1'b0; cyc = 1'b0; we = 1'b0; end
      end else if (!stb && $urandom_range(0, 2) == 0) begin
        cyc = ($urandom_range(0, 7) != 0);
        stb = 1'b1;
        we  = $urandom_range(0, 1);
        adr = 3'($urandom_range(0, 7));
        dat = 8'($urandom);
        if (adr == 3'd3 && $urandom_range(0, 1) == 0) dat[7] = 1'b0;
      end else if (stb && !cyc) begin
        cyc = 1'b1;
      end
      sel = $urandom_range(0, 1);
      rxv = ($urandom_range(0, 4) == 0);
      rxd = 8'($urandom);
      txr = ($urandom_range(0, 2) == 0);
    end
    @(posedge clk); #1;
    stb = 1'b0; cyc = 1'b0; we = 1'b0; rxv = 1'b0; txr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
